pipe_kogge_stone_sub: RTL and testbench

- Two-stage pipelined N-bit subtractor: computes DIFF = A - B - bin with valid/ready handshakes on both sides.
- Each stage is built from the team's Kogge-Stone prefix cells (B_cell/G_cell/buffer): subtraction is A + ~B + ~bin.
- Stage 1 resolves the lower half and registers the carry out of the lower half; stage 2 resolves the upper half.
- Sits in the datapath next to the pipelined adder; used by compare/decrement paths that need the borrow and signed-overflow flags.

---
 rtl/pipe_kogge_stone_sub.sv | 180 ++++++++++++++++++
 tb/tb_pipe_kogge_stone_sub.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_kogge_stone_sub.sv
// Two-stage pipelined subtractor: diff = A - B - bin, computed as A + ~B + ~bin.
// Stage 1 resolves the lower half and registers its carry.
// Stage 2 resolves the upper half and registers diff together with the borrow, zero and overflow flags.
// Flow control stalls the whole pipe; there is no skid buffer.

// Kogge-Stone adder: o_sum = i_a + i_b + i_cin, with o_cout as the carry out.
// The carry in is folded in as an extra generate bit below bit 0, so the prefix tree also produces every carry.
module ks_add #(
  parameter int W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  localparam int L = $clog2(W + 1);

  // Prefix (G,P) per level. The last level only needs G, so P stops one level short.
  logic [W:0] w_g [0:L];
  logic [W:0] w_p [0:L-1];

  // Black cell: combines group generate and group propagate.
  function automatic logic [1:0] b_cell(input logic g_hi, input logic p_hi,
                                        input logic g_lo, input logic p_lo);
    return {g_hi | (p_hi & g_lo), p_hi & p_lo};
  endfunction

  // Gray cell: the final level only needs the generate term.
  function automatic logic g_cell(input logic g_hi, input logic p_hi, input logic g_lo);
    return g_hi | (p_hi & g_lo);
  endfunction

  // Prefix tree. Bits whose span is already complete pass through as buffers.
  always_comb begin
    for (int lv = 0; lv <= L; lv++) w_g[lv] = '0;
    for (int lv = 0; lv < L; lv++) w_p[lv] = '0;
    w_g[0] = {i_a & i_b, i_cin};
    w_p[0] = {i_a ^ i_b, 1'b0};
    for (int lv = 0; lv < L; lv++) begin
      for (int i = 0; i <= W; i++) begin
        if (i < (1 << lv)) begin
          w_g[lv+1][i] = w_g[lv][i];
          if (lv + 1 < L) w_p[lv+1][i] = w_p[lv][i];
        end else if (lv + 1 < L) begin
          {w_g[lv+1][i], w_p[lv+1][i]} = b_cell(w_g[lv][i], w_p[lv][i],
                                                w_g[lv][i-(1<<lv)], w_p[lv][i-(1<<lv)]);
        end else begin
          w_g[lv+1][i] = g_cell(w_g[lv][i], w_p[lv][i], w_g[lv][i-(1<<lv)]);
        end
      end
    end
  end

  // Extended bit j holds the carry into operand bit j.
  assign o_sum  = w_p[0][W:1] ^ w_g[L][W-1:0];
  assign o_cout = w_g[L][W];

endmodule

module pipe_kogge_stone_sub #(
  parameter int bw  = 32,
  parameter int hbw = bw / 2
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [bw-1:0] A,
  input  logic [bw-1:0] B,
  input  logic          bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [bw-1:0] diff,
  output logic          bout,
  output logic          zero,
  output logic          ovf
);

  localparam int UW = bw - hbw;

  logic            r_s1_valid;
  logic [hbw-1:0]  r_lo_diff;
  logic            r_c_lo;
  logic [UW-1:0]   r_a_hi;
  logic [UW-1:0]   r_nb_hi;
  logic            r_sa;
  logic            r_sb;

  logic            r_out_valid;
  logic [bw-1:0]   r_diff;
  logic            r_bout;
  logic            r_zero;
  logic            r_ovf;

  logic            w_adv1;
  logic            w_adv2;
  logic            w_accept;
  logic [hbw-1:0]  w_nb_lo;
  logic [hbw-1:0]  w_lo_sum;
  logic            w_c_lo;
  logic [UW-1:0]   w_hi_sum;
  logic            w_c_hi;
  logic [bw-1:0]   w_diff_nxt;

  assign w_adv2   = ~r_out_valid | out_ready;
  assign w_adv1   = ~r_s1_valid | w_adv2;
  assign w_accept = in_valid & w_adv1;
  assign in_ready = w_adv1;

  assign w_nb_lo = ~B[hbw-1:0];

  ks_add #(.W(hbw)) u_lo (
    .i_a    (A[hbw-1:0]),
    .i_b    (w_nb_lo),
    .i_cin  (~bin),
    .o_sum  (w_lo_sum),
    .o_cout (w_c_lo)
  );

  ks_add #(.W(UW)) u_hi (
    .i_a    (r_a_hi),
    .i_b    (r_nb_hi),
    .i_cin  (r_c_lo),
    .o_sum  (w_hi_sum),
    .o_cout (w_c_hi)
  );

  assign w_diff_nxt = {w_hi_sum, r_lo_diff};

  // Stage 1: register the lower-half result, its carry and the raw upper-half operands.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_s1_valid <= 1'b0;
      r_lo_diff  <= '0;
      r_c_lo     <= 1'b0;
      r_a_hi     <= '0;
      r_nb_hi    <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
    end else if (w_adv1) begin
      r_s1_valid <= in_valid;
      if (w_accept) begin
        r_lo_diff <= w_lo_sum;
        r_c_lo    <= w_c_lo;
        r_a_hi    <= A[bw-1:hbw];
        r_nb_hi   <= ~B[bw-1:hbw];
        r_sa      <= A[bw-1];
        r_sb      <= B[bw-1];
      end
    end
  end

  // Stage 2: finish the upper half and register diff with all flags in the same edge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_out_valid <= 1'b0;
      r_diff      <= '0;
      r_bout      <= 1'b0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
    end else if (w_adv2) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_diff <= w_diff_nxt;
        r_bout <= ~w_c_hi;
        r_zero <= ~|w_diff_nxt;
        r_ovf  <= (r_sa ^ r_sb) & (w_diff_nxt[bw-1] ^ r_sa);
      end
    end
  end

  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign zero      = r_zero;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_pipe_kogge_stone_sub.sv
// Bench for pipe_kogge_stone_sub: directed cases, then randomized traffic against an arithmetic reference model.
module tb_pipe_kogge_stone_sub;

  localparam int BW = 32;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] A = '0;
  logic [BW-1:0] B = '0;
  logic          bin = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] diff;
  logic          bout;
  logic          zero;
  logic          ovf;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        bo;
    logic        z;
    logic        ov;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] log_q[$];
  exp_t        mon_e;

  always #5 CLK = ~CLK;

  pipe_kogge_stone_sub #(.bw(BW)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .zero      (zero),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain wide unsigned and signed arithmetic.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic bi);
    exp_t        e;
    logic [32:0] full;
    longint      s;
    full = {1'b0, a} - {1'b0, b} - {32'b0, bi};
    s    = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
    e.d  = full[31:0];
    e.bo = full[32];
    e.z  = (full[31:0] == 32'd0);
    e.ov = (s > longint'(32'sh7fff_ffff)) || (s < longint'(32'sh8000_0000));
    return e;
  endfunction

  function automatic logic [31:0] rnd_val();
    logic [31:0] edges [7];
    edges = '{32'h0, 32'h1, 32'h7fff_ffff, 32'h8000_0000, 32'hffff_ffff, 32'h0000_ffff, 32'h0001_0000};
    if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 6)];
    return $urandom;
  endfunction

  // Scoreboard: retire transfers in order, then record newly accepted beats.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (out_valid && out_ready) begin
        log_q.push_back(diff);
        if (exp_q.size() == 0) begin
          chk("spurious_out", {63'b0, out_valid}, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("sb_diff", {32'b0, diff}, {32'b0, mon_e.d});
          chk("sb_bout", {63'b0, bout}, {63'b0, mon_e.bo});
          chk("sb_zero", {63'b0, zero}, {63'b0, mon_e.z});
          chk("sb_ovf",  {63'b0, ovf},  {63'b0, mon_e.ov});
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(A, B, bin));
        n_acc++;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_one(input logic [31:0] a, input logic [31:0] b, input logic bi);
    int guard;
    guard = 0;
    A = a; B = b; bin = bi; in_valid = 1'b1;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    if (!in_ready) chk("send_timeout", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic bo,
                            input logic z, input logic ov);
    int w;
    w = 0;
    while (!out_valid && w < 50) begin
      tick();
      w++;
    end
    chk({tag, "_valid"}, {63'b0, out_valid}, 64'd1);
    chk({tag, "_diff"},  {32'b0, diff}, {32'b0, d});
    chk({tag, "_bout"},  {63'b0, bout}, {63'b0, bo});
    chk({tag, "_zero"},  {63'b0, zero}, {63'b0, z});
    chk({tag, "_ovf"},   {63'b0, ovf},  {63'b0, ov});
    tick();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int guard;
    int cyc;
    int start;
    bit did_rst;

    // Reset state
    #2;
    chk("rst_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_diff",  {32'b0, diff}, 64'd0);
    chk("rst_flags", {61'b0, bout, zero, ovf}, 64'd0);
    tick();
    tick();
    RESET = 1'b0;
    #1;
    chk("rst_rel_ready", {63'b0, in_ready}, 64'd1);

    // Asynchronous reset between edges with beats in flight
    out_ready = 1'b0;
    send_one(32'd5, 32'd3, 1'b0);
    tick();
    chk("pre_rst_valid", {63'b0, out_valid}, 64'd1);
    chk("pre_rst_diff",  {32'b0, diff}, 64'd2);
    A = 32'd7; B = 32'd1; bin = 1'b0; in_valid = 1'b1;
    #2;
    RESET = 1'b1;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_diff",  {32'b0, diff}, 64'd0);
    chk("arst_flags", {61'b0, bout, zero, ovf}, 64'd0);
    exp_q.delete();
    in_valid = 1'b0;
    #1;
    RESET = 1'b0;
    #1;
    chk("arst_rel_ready", {63'b0, in_ready}, 64'd1);
    tick();
    tick();
    chk("arst_no_stale", {63'b0, out_valid}, 64'd0);

    // Basic subtraction and two-edge latency
    out_ready = 1'b1;
    send_one(32'd5, 32'd3, 1'b0);
    chk("lat_early", {63'b0, out_valid}, 64'd0);
    tick();
    chk("lat_k1", {63'b0, out_valid}, 64'd1);
    expect_out("basic", 32'd2, 1'b0, 1'b0, 1'b0);

    // Borrow across the half boundary
    send_one(32'h0001_0000, 32'h1, 1'b0);
    expect_out("half1", 32'h0000_ffff, 1'b0, 1'b0, 1'b0);
    send_one(32'h0, 32'h1, 1'b0);
    expect_out("half2", 32'hffff_ffff, 1'b1, 1'b0, 1'b0);

    // Flags
    send_one(32'h8000_0000, 32'h1, 1'b0);
    expect_out("ovf_neg", 32'h7fff_ffff, 1'b0, 1'b0, 1'b1);
    send_one(32'h7fff_ffff, 32'hffff_ffff, 1'b0);
    expect_out("ovf_pos", 32'h8000_0000, 1'b1, 1'b0, 1'b1);
    send_one(32'h1234, 32'h1234, 1'b0);
    expect_out("zero", 32'h0, 1'b0, 1'b1, 1'b0);
    send_one(32'h1234, 32'h1234, 1'b1);
    expect_out("bin_eq", 32'hffff_ffff, 1'b1, 1'b0, 1'b0);

    // Backpressure: two beats fill the pipe, outputs hold, then drain in order
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
      tick();
      guard++;
    end
    out_ready = 1'b0;
    log_q.delete();
    A = 32'd10; B = 32'd1; bin = 1'b0; in_valid = 1'b1;
    chk("bp_rdy0", {63'b0, in_ready}, 64'd1);
    tick();
    A = 32'd20; B = 32'd2;
    chk("bp_rdy1", {63'b0, in_ready}, 64'd1);
    tick();
    A = 32'd30; B = 32'd3;
    chk("bp_full",  {63'b0, in_ready}, 64'd0);
    chk("bp_valid", {63'b0, out_valid}, 64'd1);
    chk("bp_hold0", {32'b0, diff}, 64'd9);
    tick();
    tick();
    chk("bp_hold1", {32'b0, diff}, 64'd9);
    chk("bp_still_full", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_comb_rdy", {63'b0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
      tick();
      guard++;
    end
    chk("bp_count", log_q.size(), 64'd3);
    if (log_q.size() == 3) begin
      chk("bp_out0", {32'b0, log_q[0]}, 64'd9);
      chk("bp_out1", {32'b0, log_q[1]}, 64'd18);
      chk("bp_out2", {32'b0, log_q[2]}, 64'd27);
    end

    // Random traffic with one reset mid-stream
    cyc = 0;
    start = n_acc;
    did_rst = 1'b0;
    while ((n_acc - start) < 10000 && cyc < 80000) begin
      if (!did_rst && (n_acc - start) >= 5000) begin
        did_rst = 1'b1;
        in_valid = 1'b0;
        RESET = 1'b1;
        #1;
        exp_q.delete();
        tick();
        RESET = 1'b0;
        tick();
        tick();
        chk("rnd_rst_flush", {63'b0, out_valid}, 64'd0);
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      A         = rnd_val();
      B         = ($urandom_range(0, 7) == 0) ? A : rnd_val();
      bin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      cyc++;
    end
    chk("rnd_beats_done", {63'b0, ((n_acc - start) >= 10000)}, 64'd1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
      tick();
      guard++;
    end
    chk("drain_left", exp_q.size(), 64'd0);
    chk("drain_valid", {63'b0, out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
